led_flow_engine: RTL and testbench
==================================

# led_flow_engine

Parametrised flowing-LED pattern generator: an internal programmable prescaler produces a step tick, and a pattern register advances one step per tick in one of four modes (rotate, bounce, fill, blink). It is the general-width, multi-mode successor of the fixed 16-LED single-pattern flow block. It drives the board LED bank directly, with `mode`, `dir` and `en` taken from switches and `div` from a constant or a register.

## Interface
- `LED_W`, 16, number of LEDs; legal range 2..64.
- `DIV_W`, 32, width of the prescaler divisor and counter.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `en`  input  1  1 = prescaler runs; 0 = counter and pattern freeze.
- `mode`  input  2  pattern mode: 00 ROTATE, 01 BOUNCE, 10 FILL, 11 BLINK.
- `dir`  input  1  0 = toward MSB (left), 1 = toward LSB (right).
- `div`  input  DIV_W  step period in clk cycles; 0 is treated as 1.
- `led`  output  LED_W  pattern register, 1 = LED on.
- `tick`  output  1  registered one-cycle pulse on each pattern step.

## Operation
- Reset (`rst_n`=0 at an edge) sets: `cnt`=0, `led`=LED_W'h1, `tick`=0, `mode_q`=00, `dir_q`=0, bounce state `UP`.
- Effective divisor: `div_eff` = (`div`==0) ? 1 : `div`.
- Prescaler, when `en`=1 and no reload is pending:
  - If `cnt` >= `div_eff`-1: `cnt`<=0, `tick`<=1, `led`<=next pattern.
  - Otherwise `cnt`<=`cnt`+1 and `tick`<=0.
  - The >= compare means that shrinking `div` below `cnt` produces a tick on the next edge.
- When `en`=0: `cnt` and `led` hold and `tick`<=0.
- Reload. `mode_q` and `dir_q` register `mode` and `dir` every cycle. A reload is triggered when `mode`!=`mode_q`, or when `dir`!=`dir_q` while in BOUNCE or FILL. On a reload:
  - `led`<=seed, `cnt`<=0, `tick`<=0.
  - Bounce state <= (`dir` ? `DOWN` : `UP`).
  - Reload beats a same-cycle tick and applies even when `en`=0.
- Seed value:
  - ROTATE, BOUNCE, FILL: bit 0 set when `dir`=0; bit LED_W-1 set when `dir`=1.
  - BLINK: all ones.
- ROTATE:
  - `dir`=0: rotate left by 1 (MSB wraps to bit 0).
  - `dir`=1: rotate right by 1.
  - A `dir` change does not reload; the next step moves the one-hot bit from its current position.
- BOUNCE, a 2-state FSM `UP`/`DOWN`:
  - `UP` shifts left; `DOWN` shifts right.
  - Reaching bit LED_W-1 while `UP` switches to `DOWN`; the next step goes to bit LED_W-2, so the end bit shows for exactly one step.
  - Reaching bit 0 while `DOWN` switches to `UP` symmetrically.
- FILL, sequence per `dir`:
  - `dir`=0: `led`<=(`led`<<1)|1 until all ones; the next step gives all zeros; the next step gives the seed.
  - `dir`=1: mirror of the above, filling from the MSB.
- BLINK: `led`<=~`led` each step.

## Timing
- `tick` and the new `led` value appear on the same clock edge; `led` is stable for `div_eff` cycles between steps.
- Step period is exactly `div_eff` cycles with `en` held high.
- With `div`=0 or 1, a tick occurs every cycle.
- Reload latency: the seed appears on the first edge after `mode`/`dir` changes. The first step after that comes `div_eff` cycles later.
- De-asserting `en` freezes `cnt` mid-count; re-asserting resumes from the frozen value with no extra tick.
- Inputs `mode` and `dir` are synchronised upstream; this block does not debounce.

## Test plan
- ROTATE, LED_W=16, `div`=4, `dir`=0, after reset: `led` goes 0x0001, 0x0002, 0x0004 …, with `tick` every 4th cycle; 0x8000 -> 0x0001. Set `dir`=1 at 0x0010: the next step gives 0x0008, with no reload.
- BOUNCE, `div`=1: from reset, `mode`=01 gives seed 0x0001, then 0x0002 … 0x8000, 0x4000 … 0x0001, 0x0002. The period is 30 steps and each end is visited once.
- FILL: `dir`=0 gives 0x0001, 0x0003 … 0xFFFF, 0x0000, 0x0001. Toggle to `dir`=1 mid-fill: the next edge gives 0x8000, `cnt`=0, and the next step 0xC000.
- BLINK plus `en`, `div`=3: `led` 0xFFFF/0x0000 alternates every 3 cycles. Drop `en` for 10 cycles: `led` and `cnt` hold and `tick`=0. Re-enable: the step lands exactly where the count resumed.
- Divisor edge cases:
  - `div`=0 ticks every cycle.
  - Change `div` from 100 to 5 while `cnt`=50: tick on the next edge, then a 5-cycle period.
  - Mode change on the same cycle as a due tick: the reload wins, `tick`=0 and `led`=seed.
- Reset mid-run: assert `rst_n`=0 for one edge while in FILL at 0x00FF with `mode` still 10. The next edge gives `led`=0x0001 and `tick`=0. The following edge reloads the FILL seed 0x0001 (mode 10 differs from the reset value of `mode_q`).

Source files
------------

// File: rtl/led_flow_if.sv
// led_flow_if: control inputs and LED-bank outputs of the flowing-LED engine
interface led_flow_if #(
    parameter int LED_W = 16,
    parameter int DIV_W = 32
);
    logic             en;
    logic [1:0]       mode;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic [LED_W-1:0] led;
    logic             tick;
    modport master(output en, mode, dir, div, input led, tick);
    modport slave(input en, mode, dir, div, output led, tick);
endinterface

// File: rtl/led_flow_engine.sv
// led_flow_engine: prescaled multi-mode (rotate/bounce/fill/blink) LED pattern generator
module led_flow_engine #(
    parameter int LED_W = 16,
    parameter int DIV_W = 32
) (
    input logic clk,
    input logic rst_n,
    led_flow_if.slave bus
);
    localparam logic [1:0] ROTATE = 2'b00;
    localparam logic [1:0] BOUNCE = 2'b01;
    localparam logic [1:0] FILL   = 2'b10;
    localparam logic [LED_W-1:0] LSB_HOT = LED_W'(1);
    localparam logic [LED_W-1:0] MSB_HOT = LSB_HOT << (LED_W - 1);

    typedef enum logic {UP, DOWN} bounce_t;

    bounce_t          state_q, state_d;
    logic [DIV_W-1:0] cnt, div_eff;
    logic [LED_W-1:0] led_q, seed, step_led;
    logic [1:0]       mode_q;
    logic             dir_q, tick_q, reload, due;

    always_comb begin
        div_eff  = (bus.div == '0) ? DIV_W'(1) : bus.div;
        due      = bus.en && (cnt >= div_eff - DIV_W'(1));
        reload   = (bus.mode != mode_q) || (bus.dir != dir_q && (bus.mode == BOUNCE || bus.mode == FILL));
        seed     = (bus.mode == 2'b11) ? '1 : bus.dir ? MSB_HOT : LSB_HOT;
        step_led = ~led_q;
        state_d  = state_q;
        case (bus.mode)
            ROTATE:  step_led = bus.dir ? {led_q[0], led_q[LED_W-1:1]} : {led_q[LED_W-2:0], led_q[LED_W-1]};
            BOUNCE:  step_led = (state_q == UP) ? led_q << 1 : led_q >> 1;
            FILL:    step_led = (&led_q) ? '0 : (led_q == '0) ? seed :
                                bus.dir ? (led_q >> 1) | MSB_HOT : (led_q << 1) | LSB_HOT;
            default: step_led = ~led_q;
        endcase
        // an end bit is shown for exactly one step before the direction flips
        if (reload)
            state_d = bus.dir ? DOWN : UP;
        else if (due && bus.mode == BOUNCE)
            state_d = (state_q == UP && step_led[LED_W-1]) ? DOWN :
                      (state_q == DOWN && step_led[0]) ? UP : state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= UP;
            cnt     <= '0;
            led_q   <= LSB_HOT;
            tick_q  <= 1'b0;
            mode_q  <= ROTATE;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= bus.mode;
            dir_q   <= bus.dir;
            if (reload) begin
                led_q  <= seed;
                cnt    <= '0;
                tick_q <= 1'b0;
            end else if (due) begin
                led_q  <= step_led;
                cnt    <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt    <= bus.en ? cnt + DIV_W'(1) : cnt;
                tick_q <= 1'b0;
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_flow_engine.sv
// tb_led_flow_engine: directed and random stimulus against a position/level pattern model
module tb_led_flow_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int m_kind = 0, m_pos = 0, m_level = 0, m_cnt = 0, m_mq = 0;
    bit m_up = 1'b1, m_side = 1'b0, m_on = 1'b0, m_tick = 1'b0, m_dq = 1'b0;

    led_flow_if #(.LED_W(16), .DIV_W(32)) bus ();
    led_flow_engine #(.LED_W(16), .DIV_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_led();
        case (m_kind)
            0, 1: return 16'(32'd1 << m_pos);
            2: begin
                if (m_level == 0) return 16'h0000;
                if (!m_side) return 16'((32'd1 << m_level) - 1);
                return 16'(~((32'd1 << (16 - m_level)) - 1));
            end
            default: return m_on ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic advance();
        case (m_kind)
            0: m_pos = bus.dir ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
            1: begin
                if (m_up) begin
                    m_pos++;
                    if (m_pos == 15) m_up = 1'b0;
                end else begin
                    m_pos--;
                    if (m_pos == 0) m_up = 1'b1;
                end
            end
            2: m_level = (m_level + 1) % 17;
            default: m_on = !m_on;
        endcase
    endtask

    task automatic model_edge();
        int deff;
        bit rl;
        if (!rst_n) begin
            m_kind = 0; m_pos = 0; m_cnt = 0; m_tick = 0; m_mq = 0; m_dq = 0; m_up = 1;
        end else begin
            deff = (bus.div == 0) ? 1 : int'(bus.div);
            rl = (int'(bus.mode) != m_mq) || (bus.dir != m_dq && (bus.mode == 2'd1 || bus.mode == 2'd2));
            if (rl) begin
                m_kind = int'(bus.mode);
                m_pos = bus.dir ? 15 : 0;
                m_up = !bus.dir;
                m_side = bus.dir;
                m_level = 1;
                m_on = 1'b1;
                m_cnt = 0;
                m_tick = 0;
            end else if (bus.en) begin
                if (m_cnt >= deff - 1) begin
                    m_cnt = 0;
                    m_tick = 1;
                    advance();
                end else begin
                    m_cnt++;
                    m_tick = 0;
                end
            end else begin
                m_tick = 0;
            end
            m_mq = int'(bus.mode);
            m_dq = bus.dir;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("led", 64'(bus.led), 64'(model_led()));
        check("tick", 64'(bus.tick), 64'(m_tick));
    endtask

    initial begin
        bus.en = 1'b1; bus.mode = 2'd0; bus.dir = 1'b0; bus.div = 32'd4;
        step();
        step();
        check("rst_led", 64'(bus.led), 64'h0001);
        check("rst_tick", 64'(bus.tick), 64'h0);
        rst_n = 1'b1;
        repeat (3) step();
        check("rot_idle_tick", 64'(bus.tick), 64'h0);
        step();
        check("rot_first", 64'(bus.led), 64'h0002);
        check("rot_first_tick", 64'(bus.tick), 64'h1);
        repeat (8) step();
        bus.dir = 1'b1;
        repeat (8) step();
        check("rot_right", 64'(bus.led), 64'h0002);
        // bounce full period
        bus.mode = 2'd1; bus.dir = 1'b0; bus.div = 32'd1; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("bnc_seed", 64'(bus.led), 64'h0001);
        repeat (15) step();
        check("bnc_top", 64'(bus.led), 64'h8000);
        repeat (15) step();
        check("bnc_bottom", 64'(bus.led), 64'h0001);
        // fill with mid-fill dir toggle
        bus.mode = 2'd2;
        step();
        repeat (4) step();
        check("fill_mid", 64'(bus.led), 64'h001F);
        bus.dir = 1'b1;
        step();
        check("fill_reseed", 64'(bus.led), 64'h8000);
        step();
        check("fill_msb2", 64'(bus.led), 64'hC000);
        // reset in the middle of a fill
        bus.dir = 1'b0;
        step();
        repeat (7) step();
        check("fill_ff", 64'(bus.led), 64'h00FF);
        rst_n = 1'b0;
        step();
        check("mid_rst_led", 64'(bus.led), 64'h0001);
        check("mid_rst_tick", 64'(bus.tick), 64'h0);
        rst_n = 1'b1;
        step();
        check("post_rst_seed", 64'(bus.led), 64'h0001);
        step();
        check("post_rst_step", 64'(bus.led), 64'h0003);
        // blink with enable freeze mid-count
        bus.mode = 2'd3; bus.div = 32'd3;
        step();
        repeat (3) step();
        check("blink_off", 64'(bus.led), 64'h0000);
        step();
        bus.en = 1'b0;
        repeat (10) step();
        check("frz_led", 64'(bus.led), 64'h0000);
        bus.en = 1'b1;
        step();
        check("resume_wait", 64'(bus.tick), 64'h0);
        step();
        check("resume_tick", 64'(bus.tick), 64'h1);
        check("resume_led", 64'(bus.led), 64'hFFFF);
        bus.div = 32'd0;
        step();
        check("div0_tick", 64'(bus.tick), 64'h1);
        // shrink divisor below the running count
        bus.mode = 2'd0; bus.div = 32'd100;
        step();
        repeat (50) step();
        bus.div = 32'd5;
        step();
        check("shrink_tick", 64'(bus.tick), 64'h1);
        repeat (4) step();
        check("shrink_gap", 64'(bus.tick), 64'h0);
        step();
        check("shrink_period", 64'(bus.tick), 64'h1);
        // reload against a due tick
        bus.div = 32'd1;
        step();
        bus.mode = 2'd3;
        step();
        check("reload_wins_tick", 64'(bus.tick), 64'h0);
        check("reload_wins_led", 64'(bus.led), 64'hFFFF);
        for (int seg = 0; seg < 80; seg++) begin
            bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) bus.dir = ~bus.dir;
            bus.div = 32'($urandom_range(0, 6));
            bus.en = ($urandom_range(0, 4) != 0);
            rst_n = ($urandom_range(0, 14) != 0);
            for (int c = 0, len = $urandom_range(1, 60); c < len; c++) begin
                step();
                rst_n = 1'b1;
                if ($urandom_range(0, 9) == 0) bus.en = ~bus.en;
                if ($urandom_range(0, 29) == 0) bus.div = 32'($urandom_range(0, 6));
                if (bus.mode == 2'd0 && $urandom_range(0, 19) == 0) bus.dir = ~bus.dir;
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
